// File: rtl/ib_lut_pkg.sv
// Shared definitions for the IB LUT page loader and the LUT cells it feeds.
// Holds the loader state encoding and the default page geometry.
package ib_lut_pkg;

    localparam int LUT_WR_BITWIDTH      = 3;
    localparam int LUT_WR_ADDR_BITWIDTH = 5;
    localparam int LUT_VN_LOAD_CYCLE    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } lut_load_state_e;

    // A page is in flight while entries are being taken or the last write drains.
    function automatic logic state_is_busy(input lut_load_state_e st);
        return (st == ST_LOAD) || (st == ST_FLUSH);
    endfunction

endpackage

// File: rtl/vn_lut_load_ctrl.sv
// Page loader for the variable-node LUT: streams one page of entries into
// both LUT port copies, with abort, rejected-start and completion signalling.
module vn_lut_load_ctrl
    import ib_lut_pkg::*;
#(
    parameter int WR_BITWIDTH      = LUT_WR_BITWIDTH,
    parameter int WR_ADDR_BITWIDTH = LUT_WR_ADDR_BITWIDTH,
    parameter int VN_LOAD_CYCLE    = LUT_VN_LOAD_CYCLE
) (
    input  logic                        write_clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic                        load_abort,
    input  logic [WR_BITWIDTH-1:0]      in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        we,
    output logic [WR_ADDR_BITWIDTH-1:0] write_addr_replicate_0,
    output logic [WR_ADDR_BITWIDTH-1:0] write_addr_replicate_1,
    output logic [WR_BITWIDTH-1:0]      lut_in_replicate_0,
    output logic [WR_BITWIDTH-1:0]      lut_in_replicate_1,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        lut_valid,
    output logic                        load_err
);

    localparam logic [WR_ADDR_BITWIDTH-1:0] LAST_IDX = WR_ADDR_BITWIDTH'(VN_LOAD_CYCLE - 1);

    lut_load_state_e               state_q, state_d;
    logic [WR_ADDR_BITWIDTH-1:0]   cnt_q,   cnt_d;
    logic [WR_ADDR_BITWIDTH-1:0]   addr_q,  addr_d;
    logic [WR_BITWIDTH-1:0]        data_q,  data_d;
    logic                          we_q,    we_d;
    logic                          busy_q,  busy_d;
    logic                          done_q,  done_d;
    logic                          valid_q, valid_d;
    logic                          err_q,   err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                // Abort wins over a coinciding accept: that entry is dropped.
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = in_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered busy tracks the state the FSM is entering.
        busy_d = state_is_busy(state_d);
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign in_ready               = (state_q == ST_LOAD);
    assign we                     = we_q;
    assign write_addr_replicate_0 = addr_q;
    assign write_addr_replicate_1 = addr_q;
    assign lut_in_replicate_0     = data_q;
    assign lut_in_replicate_1     = data_q;
    assign load_busy              = busy_q;
    assign load_done              = done_q;
    assign lut_valid              = valid_q;
    assign load_err               = err_q;

endmodule

// File: tb/tb_vn_lut_load_ctrl.sv
// Scoreboard bench for vn_lut_load_ctrl: stimulus queues expected LUT writes and
// completion pulses, a negedge monitor pops and compares them as the DUT emits.
module tb_vn_lut_load_ctrl;

    localparam int DW = 3;
    localparam int AW = 5;
    localparam int NE = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          load_abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] ld0, ld1;
    logic          load_busy;
    logic          load_done;
    logic          lut_valid;
    logic          load_err;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];

    always #5 clk = ~clk;

    vn_lut_load_ctrl #(
        .WR_BITWIDTH(DW),
        .WR_ADDR_BITWIDTH(AW),
        .VN_LOAD_CYCLE(NE)
    ) dut (
        .write_clk(clk),
        .rst(rst),
        .load_start(load_start),
        .load_abort(load_abort),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .we(we),
        .write_addr_replicate_0(wa0),
        .write_addr_replicate_1(wa1),
        .lut_in_replicate_0(ld0),
        .lut_in_replicate_1(ld1),
        .load_busy(load_busy),
        .load_done(load_done),
        .lut_valid(lut_valid),
        .load_err(load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write at %0t",
                         wa0, ld0, $time);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr0", 32'(wa0), 32'(e.addr));
                check("wr_addr1", 32'(wa1), 32'(e.addr));
                check("wr_data0", 32'(ld0), 32'(e.data));
                check("wr_data1", 32'(ld1), 32'(e.data));
            end
        end
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got load_done 1 expected 0 at %0t", $time);
            end else begin
                void'(done_q.pop_front());
                check("done_lut_valid", 32'(lut_valid), 32'd1);
                check("done_busy", 32'(load_busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        load_abort = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_busy", 32'(load_busy), 32'd1);
        check("start_lut_valid", 32'(lut_valid), 32'd0);
    endtask

    // Drive entries first..last with value i mod 8, all expected to be written.
    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i % 8);
            wr_q.push_back({AW'(i), DW'(i % 8)});
            if (i == NE - 1) done_q.push_back(1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_page();
        // FLUSH cycle carries the last write, done lands one cycle later.
        check("flush_we", 32'(we), 32'd1);
        check("flush_busy", 32'(load_busy), 32'd1);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("done_pulse", 32'(load_done), 32'd1);
        tick();
        check("done_single", 32'(load_done), 32'd0);
        check("lut_valid_hold", 32'(lut_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_addr"}, 32'({wa0, wa1}), 32'd0);
        check({tag, "_data"}, 32'({ld0, ld1}), 32'd0);
        check({tag, "_flags"}, 32'({load_busy, load_done, lut_valid, load_err, in_ready}), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full back-to-back page.
        start_load();
        send_range(0, NE - 1);
        finish_page();

        // in_valid gap of three cycles after entry 10.
        start_load();
        send_range(0, 10);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("gap_we", 32'(we), 32'd0);
            check("gap_in_ready", 32'(in_ready), 32'd1);
        end
        send_range(11, NE - 1);
        finish_page();

        // Abort coinciding with the accept of entry 5.
        start_load();
        send_range(0, 4);
        in_valid   = 1'b1;
        in_data    = 3'd5;
        load_abort = 1'b1;
        tick();
        idle_inputs();
        check("abort_we", 32'(we), 32'd0);
        check("abort_busy", 32'(load_busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_lut_valid", 32'(lut_valid), 32'd0);
        tick();
        tick();
        check("abort_no_done", 32'(load_done), 32'd0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check("abort_idle_ignored", 32'(load_busy), 32'd0);

        // Rejected load_start while counter is 7.
        start_load();
        send_range(0, 6);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 3'd7;
        wr_q.push_back({AW'(7), DW'(7)});
        tick();
        load_start = 1'b0;
        check("err_pulse", 32'(load_err), 32'd1);
        check("err_busy", 32'(load_busy), 32'd1);
        send_range(8, 8);
        check("err_single", 32'(load_err), 32'd0);
        send_range(9, NE - 1);
        // load_start and load_abort during FLUSH: error pulse, page still completes.
        load_start = 1'b1;
        load_abort = 1'b1;
        check("flush_we", 32'(we), 32'd1);
        tick();
        idle_inputs();
        check("flush_err", 32'(load_err), 32'd1);
        check("flush_done", 32'(load_done), 32'd1);
        tick();

        // Reset while counter is 20, then a fresh page from address 0.
        start_load();
        send_range(0, 19);
        in_valid = 1'b1;
        in_data  = 3'd4;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check_all_zero("midrst");
        tick();
        check("midrst_no_done", 32'(load_done), 32'd0);
        start_load();
        send_range(0, NE - 1);
        finish_page();

        tick();
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vn_lut_load_ctrl.md
VN_LUT_LOAD_CTRL -- requirements
Module: vn_lut_load_ctrl

Interface
REQ-001 SHALL have parameter WR_BITWIDTH, default 3: width of one LUT entry.
REQ-002 SHALL have parameter WR_ADDR_BITWIDTH, default 5: LUT write-address width.
REQ-003 SHALL have parameter VN_LOAD_CYCLE, default 32: entries per LUT page, at most 2^WR_ADDR_BITWIDTH.
REQ-004 SHALL have port write_clk, input, 1 bit: the only clock; every flop is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port load_start, input, 1 bit: single-cycle request to load a new page.
REQ-007 SHALL have port load_abort, input, 1 bit: cancels a load in progress.
REQ-008 SHALL have port in_data, input, WR_BITWIDTH bits: page entry stream.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-011 SHALL have port we, output, 1 bit: LUT write enable.
REQ-012 SHALL have ports write_addr_replicate_0 and write_addr_replicate_1, outputs, WR_ADDR_BITWIDTH bits each: write address for each LUT port copy.
REQ-013 SHALL have ports lut_in_replicate_0 and lut_in_replicate_1, outputs, WR_BITWIDTH bits each: write data for each LUT port copy.
REQ-014 SHALL have port load_busy, output, 1 bit: asserted in states LOAD and FLUSH.
REQ-015 SHALL have port load_done, output, 1 bit: single-cycle pulse when a full page has been written.
REQ-016 SHALL have port lut_valid, output, 1 bit: LUT contents are complete and safe to read.
REQ-017 SHALL have port load_err, output, 1 bit: single-cycle pulse when load_start is rejected.

Function
REQ-018 SHALL implement exactly three states: IDLE, LOAD, FLUSH.
REQ-019 SHALL go from IDLE to LOAD on load_start, clear the entry counter to 0, and clear lut_valid in the next cycle.
REQ-020 SHALL hold in_ready=1 only in LOAD; an entry is accepted only on a cycle with in_valid & in_ready.
REQ-021 SHALL, for an entry accepted in cycle t, drive we=1 in cycle t+1, with both write addresses equal to the counter value at t and both data outputs equal to in_data at t (identical replication).
REQ-022 SHALL drive we=0 in every cycle after which no entry was accepted; in_valid gaps stall the counter without error.
REQ-023 SHALL increment the counter by 1 per accepted entry, in the range 0..VN_LOAD_CYCLE-1, with no wrap inside a page.
REQ-024 SHALL go from LOAD to FLUSH when entry VN_LOAD_CYCLE-1 is accepted; FLUSH carries the final we=1 write.
REQ-025 SHALL go from FLUSH to IDLE unconditionally and, in that IDLE cycle, pulse load_done=1 and set lut_valid=1.
REQ-026 SHALL, on load_abort in LOAD, go to IDLE in the next cycle, write nothing, keep lut_valid=0 and not pulse load_done.
REQ-027 SHALL give load_abort priority when it coincides with an accept; the coinciding entry is not written.
REQ-028 SHALL ignore load_abort in IDLE and in FLUSH; a FLUSH completes normally.
REQ-029 SHALL ignore load_start in LOAD or FLUSH and pulse load_err=1 in the next cycle; state and counter are unchanged.
REQ-030 SHALL drive every output from a register, except in_ready, which is decoded from state.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE with counter=0, we=0, both addresses 0, both data outputs 0, load_busy=0, load_done=0, load_err=0 and lut_valid=0.
REQ-032 SHALL abandon a load cut by reset mid-operation without a done pulse; rst has priority over all other inputs.

Structure
REQ-033 SHALL take the state encoding and the VN_LOAD_CYCLE/WR_BITWIDTH/WR_ADDR_BITWIDTH defaults from a shared package, ib_lut_pkg, which the LUT cells also use.
REQ-034 SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-035 SHALL verify a full load: load_start, then 32 back-to-back entries of value (i mod 8) -> we at t+1, addr 0..31, data i mod 8 on both replicas, load_done pulse and lut_valid=1 two cycles after the last accept.
REQ-036 SHALL verify gaps: in_valid low for 3 cycles after entry 10 -> no we during the gap, next write at addr 11, load_done still after exactly 32 writes.
REQ-037 SHALL verify abort: load_abort at the cycle entry 5 is accepted -> only addrs 0..4 written, IDLE next cycle, lut_valid=0, no load_done.
REQ-038 SHALL verify rejected start: load_start during LOAD at counter 7 -> load_err pulse, counter continues at 8.
REQ-039 SHALL verify reset mid-load: rst at counter 20 -> all outputs 0 next cycle; a new load_start then writes from addr 0.
